pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Control FSM that sequences the PC block each instruction.
- Drives PCDrive/PCSet: boot vector load, fetch handshake with instruction memory, then one PC update per instruction.
- Arbitrates between sequential increment, execute-stage branches, interrupt entry and interrupt return.
- Sits between the PC block, instruction memory and the decode/execute stages.

Parameters:
ADDR_W, 32, PC/address width
RESET_VEC, 32'h0, PC loaded after reset
IRQ_VEC, 32'h21, PC loaded on interrupt entry
FETCH_TIMEOUT, 15, max cycles FetchReq may wait for FetchAck (1..255)

Ports:
clk  in  1  single clock, all logic on rising edge
nRst  in  1  synchronous active-low reset
PCAddr  in  ADDR_W  current PC from PC block
PCDrive  out  3  PC command (encodings in package)
PCSet  out  ADDR_W  operand for LOAD/REL commands
FetchReq  out  1  instruction read request at PCAddr
FetchAck  in  1  instruction memory done
InstrValid  out  1  one-cycle pulse to decode: fetched word valid
Stall  in  1  execute busy; hold PC
BranchReq  in  1  execute requests PC change
BranchTarget  in  ADDR_W  absolute target or signed offset
BranchRel  in  1  1 = PC+BranchTarget, 0 = absolute
IrqReq  in  1  level interrupt request
IrqAck  out  1  one-cycle pulse on interrupt entry
Reti  in  1  return-from-interrupt
EpcOut  out  ADDR_W  saved return address
FetchErr  out  1  sticky fetch timeout flag

Behaviour:
- PCDrive encodings: HOLD=3'b000, INC=3'b001 (PC+PC_STEP), LOAD=3'b011 (PC=PCSet), REL=3'b100 (PC+=PCSet).
- All outputs are registered.
- Reset (nRst=0 at an edge): state BOOT, PCDrive=HOLD, PCSet=0, FetchReq=0, InstrValid=0, IrqAck=0, EpcOut=0, FetchErr=0, InIrq=0.
- Reset mid-fetch drops FetchReq on that edge; a later FetchAck is ignored outside FETCH.
- FSM states:
  - BOOT: drive LOAD with PCSet=RESET_VEC for exactly 1 cycle -> SETTLE.
  - SETTLE: PCDrive=HOLD for 1 cycle while the PC block applies the command -> FETCH.
  - FETCH: FetchReq=1 and the timeout counter runs.
    - FetchAck -> InstrValid=1 next cycle, FetchReq=0 -> EXEC.
    - Counter reaches FETCH_TIMEOUT without ack -> FetchErr=1 -> HALT.
  - EXEC: PCDrive=HOLD while Stall=1. When Stall=0, issue exactly one 1-cycle command -> SETTLE. Priority:
    1. IrqReq && !InIrq: LOAD IRQ_VEC; IrqAck pulse; InIrq=1; EpcOut=destination the non-IRQ path would have taken (branch destination if BranchReq, else PCAddr+PC_STEP).
    2. BranchReq: REL with PCSet=BranchTarget if BranchRel, else LOAD with PCSet=BranchTarget.
    3. Reti && InIrq: LOAD EpcOut; InIrq=0.
    4. Otherwise INC.
  - HALT: PCDrive=HOLD, FetchReq=0; exit only via nRst.
- Stall, BranchReq, IrqReq and Reti are sampled only in EXEC.
- Reti with InIrq=0 is treated as INC.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is not an error.
- Fetch-to-fetch minimum: FETCH(ack) -> EXEC -> SETTLE -> FETCH = 3 cycles plus ack latency.

Optional Feature:
- Macro: PC_SEQUENCER_IRQ_EN.
- Defined: interrupt entry/return as above.
- Undefined: IrqReq and Reti are ignored; IrqAck=0, EpcOut=0, InIrq removed. Ports remain for a stable interface.

Decomposition:
- Package pc_seq_pkg: PCDrive encoding constants, FSM state enum (BOOT, SETTLE, FETCH, EXEC, HALT), PC_STEP=1.
- Sub-module pc_fetch_timer: 8-bit saturating counter with clear/enable and expired output, reused for FETCH timeout.

Test Plan:
- Release nRst -> 1 cycle PCDrive=011 with PCSet=0, then FetchReq=1; FetchAck after 2 cycles -> one InstrValid pulse, then PCDrive=001 for exactly 1 cycle.
- EXEC with BranchReq=1, BranchRel=0, BranchTarget=7894 -> PCDrive=011, PCSet=7894. With BranchRel=1, BranchTarget=-4 at PCAddr=10 -> PCDrive=100, PCSet=32'hFFFFFFFC, PC becomes 6.
- Stall=1 for 5 cycles in EXEC -> PCDrive=000 throughout; BranchReq during the stall acted on only after Stall drops.
- IrqReq with BranchReq to 5791 -> PCDrive=011, PCSet=33, IrqAck pulse, EpcOut=5791. Second IrqReq before Reti is ignored. Reti -> LOAD 5791.
- FetchAck never asserted -> FetchErr=1 after 15 FETCH cycles, HALT with PCDrive=000. nRst clears FetchErr and reboots to RESET_VEC.
- PCAddr=32'hFFFFFFFF with INC -> PC wraps to 0, fetch proceeds normally. Reset asserted mid-FETCH -> FetchReq=0 next edge, late ack produces no InstrValid.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: PC block commands, FSM states and PC step.
package pc_seq_pkg;
   localparam logic [2:0] PC_HOLD = 3'b000;
   localparam logic [2:0] PC_INC  = 3'b001;
   localparam logic [2:0] PC_LOAD = 3'b011;
   localparam logic [2:0] PC_REL  = 3'b100;

   localparam int PC_STEP = 1;

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_SETTLE,
      ST_FETCH,
      ST_EXEC,
      ST_HALT
   } state_t;
endpackage

// File: rtl/pc_fetch_timer.sv
// 8-bit saturating cycle counter; expired asserts on the LIMIT-th enabled cycle.
module pc_fetch_timer #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic nRst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (!nRst || clr)
         count <= '0;
      else if (en && count != 8'hFF)
         count <= count + 8'd1;
   end

   // count holds the number of cycles already spent, so the current cycle is count+1
   assign expired = (count >= 8'(LIMIT - 1));
endmodule

// File: rtl/pc_sequencer.sv
// Per-instruction PC control FSM: boot load, fetch handshake, one PC update per instruction.
// Interrupt entry/return is built only when PC_SEQUENCER_IRQ_EN is defined.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int                ADDR_W        = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC     = '0,
   parameter logic [ADDR_W-1:0] IRQ_VEC       = ADDR_W'(32'h21),
   parameter int                FETCH_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic [ADDR_W-1:0] PCAddr,
   output logic [2:0]        PCDrive,
   output logic [ADDR_W-1:0] PCSet,
   output logic              FetchReq,
   input  logic              FetchAck,
   output logic              InstrValid,
   input  logic              Stall,
   input  logic              BranchReq,
   input  logic [ADDR_W-1:0] BranchTarget,
   input  logic              BranchRel,
   input  logic              IrqReq,
   output logic              IrqAck,
   input  logic              Reti,
   output logic [ADDR_W-1:0] EpcOut,
   output logic              FetchErr
);
   state_t            state, state_nxt;
   logic [2:0]        drive_nxt;
   logic [ADDR_W-1:0] set_nxt, epc_nxt, br_dest, seq_dest;
   logic              req_nxt, valid_nxt, ack_nxt, err_nxt;
   logic              irq_take, reti_take, expired;

   pc_fetch_timer #(.LIMIT(FETCH_TIMEOUT)) u_timer (
      .clk     (clk),
      .nRst    (nRst),
      .clr     (state != ST_FETCH),
      .en      (state == ST_FETCH),
      .expired (expired)
   );

   assign br_dest  = BranchRel ? PCAddr + BranchTarget : BranchTarget;
   assign seq_dest = PCAddr + ADDR_W'(PC_STEP);

`ifdef PC_SEQUENCER_IRQ_EN
   logic in_irq, in_irq_nxt;

   assign irq_take  = IrqReq && !in_irq;
   assign reti_take = Reti && in_irq;
   assign in_irq_nxt = (state == ST_EXEC && !Stall) ?
                       (irq_take ? 1'b1 : (!BranchReq && reti_take) ? 1'b0 : in_irq) : in_irq;

   always_ff @(posedge clk) begin
      if (!nRst) in_irq <= 1'b0;
      else       in_irq <= in_irq_nxt;
   end
`else
   logic unused_irq;

   assign irq_take   = 1'b0;
   assign reti_take  = 1'b0;
   assign unused_irq = IrqReq ^ Reti;
`endif

   always_comb begin
      state_nxt = state;
      drive_nxt = PC_HOLD;
      set_nxt   = PCSet;
      req_nxt   = 1'b0;
      valid_nxt = 1'b0;
      ack_nxt   = 1'b0;
      epc_nxt   = EpcOut;
      err_nxt   = FetchErr;
      case (state)
         ST_BOOT: begin
            drive_nxt = PC_LOAD;
            set_nxt   = RESET_VEC;
            state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            req_nxt   = 1'b1;
            state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (FetchAck) begin
               valid_nxt = 1'b1;
               state_nxt = ST_EXEC;
            end else if (expired) begin
               err_nxt   = 1'b1;
               state_nxt = ST_HALT;
            end else begin
               req_nxt = 1'b1;
            end
         end
         ST_EXEC: begin
            if (!Stall) begin
               state_nxt = ST_SETTLE;
               // interrupt entry saves where this instruction would otherwise have gone
               if (irq_take) begin
                  drive_nxt = PC_LOAD;
                  set_nxt   = IRQ_VEC;
                  ack_nxt   = 1'b1;
                  epc_nxt   = BranchReq ? br_dest : seq_dest;
               end else if (BranchReq) begin
                  drive_nxt = BranchRel ? PC_REL : PC_LOAD;
                  set_nxt   = BranchTarget;
               end else if (reti_take) begin
                  drive_nxt = PC_LOAD;
                  set_nxt   = EpcOut;
               end else begin
                  drive_nxt = PC_INC;
               end
            end
         end
         ST_HALT: ;
         default: state_nxt = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         state      <= ST_BOOT;
         PCDrive    <= PC_HOLD;
         PCSet      <= '0;
         FetchReq   <= 1'b0;
         InstrValid <= 1'b0;
         IrqAck     <= 1'b0;
         EpcOut     <= '0;
         FetchErr   <= 1'b0;
      end else begin
         state      <= state_nxt;
         PCDrive    <= drive_nxt;
         PCSet      <= set_nxt;
         FetchReq   <= req_nxt;
         InstrValid <= valid_nxt;
         IrqAck     <= ack_nxt;
         EpcOut     <= epc_nxt;
         FetchErr   <= err_nxt;
      end
   end
endmodule
